// File: rtl/press_pkg.sv
// Shared types for the push-button press conditioner.
package press_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        RELEASE_PEND
    } press_state_t;

    // Counter width able to hold the value n (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/press_conditioner_if.sv
// Key inputs, game enable and press pulses between the board keys and the playfield.
interface press_conditioner_if;

    logic rawL;
    logic rawR;
    logic en;
    logic L;
    logic R;

    modport master (output rawL, output rawR, output en, input L, input R);
    modport slave  (input rawL, input rawR, input en, output L, output R);

endinterface

// File: rtl/press_channel.sv
// One key channel: 2-flop synchronizer, debounce counter/FSM and registered press pulse.
module press_channel
    import press_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic en,
    output logic pulse
);

    localparam int unsigned     CW          = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   LAST        = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   ONE         = CW'(1);
    localparam bit              SINGLE      = (DEBOUNCE_CYCLES == 1);
    localparam logic            PRESSED_LVL = ACTIVE_LOW ? 1'b0 : 1'b1;

    logic         s1;
    logic         s2;
    logic         p;
    logic [CW-1:0] cnt;
    press_state_t state;

    assign p = (s2 == PRESSED_LVL);

    // Synchronizer and FSM reset to "pressed" so a key held through reset is
    // treated as already accepted and must be released before it can pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= PRESSED_LVL;
            s2    <= PRESSED_LVL;
            state <= PRESSED;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            pulse <= 1'b0;
            case (state)
                RELEASED: begin
                    if (p) begin
                        cnt <= ONE;
                        if (SINGLE) begin
                            state <= PRESSED;
                            pulse <= en;
                        end else begin
                            state <= PRESS_PEND;
                        end
                    end
                end
                PRESS_PEND: begin
                    if (p) begin
                        cnt <= cnt + ONE;
                        if (cnt + ONE == LAST) begin
                            state <= PRESSED;
                            pulse <= en;
                        end
                    end else begin
                        state <= RELEASED;
                        cnt   <= '0;
                    end
                end
                PRESSED: begin
                    if (!p) begin
                        cnt   <= ONE;
                        state <= SINGLE ? RELEASED : RELEASE_PEND;
                    end
                end
                RELEASE_PEND: begin
                    if (!p) begin
                        cnt <= cnt + ONE;
                        if (cnt + ONE == LAST) begin
                            state <= RELEASED;
                        end
                    end else begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= RELEASED;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/press_conditioner.sv
// Two independent debounced key channels producing the playfield L/R press pulses.
module press_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input logic                 clk,
    input logic                 reset,
    press_conditioner_if.slave  bus
);

    press_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_left (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.rawL),
        .en    (bus.en),
        .pulse (bus.L)
    );

    press_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_right (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.rawR),
        .en    (bus.en),
        .pulse (bus.R)
    );

endmodule

// File: tb/tb_press_conditioner.sv
// Directed bench for press_conditioner: default build (N=4, active-low) plus an N=1 active-high build.
module tb_press_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic rst1;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    press_conditioner_if pif ();
    press_conditioner_if pif1 ();

    press_conditioner dut (
        .clk   (clk),
        .reset (reset),
        .bus   (pif)
    );

    press_conditioner #(
        .DEBOUNCE_CYCLES (1),
        .ACTIVE_LOW      (1'b0)
    ) dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (pif1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic rl;
        logic rr;
        logic en;
        int   len;
        int   lat;   // cycle index in the segment where L must be 1, -1 for never
        int   rat;
    } seg_t;

    localparam int NSEG = 23;
    seg_t tbl [0:NSEG-1];

    task automatic check(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int found;
    int nhigh;

    initial begin
        // keys are active-low on the default build: 1 = released
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1,  3, -1, -1};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 10, -1, -1};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 20,  5, -1};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 10, -1, -1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1,  1, -1, -1};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1,  1, -1, -1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1,  2, -1, -1};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1,  1, -1, -1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 12, -1,  5};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 10, -1, -1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 10,  5,  5};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 10, -1, -1};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 10,  5, -1};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 10, -1, -1};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 10, -1, -1};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 10, -1, -1};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 10, -1, -1};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b1, 10,  5, -1};
        tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b1, 10, -1, -1};
        tbl[19] = '{1'b0, 1'b0, 1'b1, 1'b1,  4, -1, -1};
        tbl[20] = '{1'b1, 1'b0, 1'b1, 1'b1,  2, -1, -1};
        tbl[21] = '{1'b0, 1'b0, 1'b1, 1'b1, 20, -1, -1};
        tbl[22] = '{1'b0, 1'b1, 1'b1, 1'b1, 10, -1, -1};

        reset     = 1'b1;
        pif.rawL  = 1'b1;
        pif.rawR  = 1'b1;
        pif.en    = 1'b1;
        rst1      = 1'b1;
        pif1.rawL = 1'b0;
        pif1.rawR = 1'b0;
        pif1.en   = 1'b1;

        for (int s = 0; s < NSEG; s++) begin
            for (int i = 0; i < tbl[s].len; i++) begin
                reset    = tbl[s].rst;
                pif.rawL = tbl[s].rl;
                pif.rawR = tbl[s].rr;
                pif.en   = tbl[s].en;
                tick();
                check($sformatf("seg%0d.%0d L", s, i), pif.L, logic'(i == tbl[s].lat));
                check($sformatf("seg%0d.%0d R", s, i), pif.R, logic'(i == tbl[s].rat));
            end
        end

        // Press latency and pulse width, with a bounded wait
        pif.rawL = 1'b0;
        found = -1;
        nhigh = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pif.L === 1'b1) begin
                nhigh++;
                if (found < 0) found = i;
            end
        end
        check_int("latency L", found, 5);
        check_int("width L", nhigh, 1);
        pif.rawL = 1'b1;
        repeat (10) tick();

        // en low only on the accepting edge: the press is lost, not deferred
        pif.rawL = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pif.en = (i == 5) ? 1'b0 : 1'b1;
            tick();
            check($sformatf("en_edge.%0d L", i), pif.L, 1'b0);
        end
        pif.en   = 1'b1;
        pif.rawL = 1'b1;
        repeat (10) tick();

        // Reset landing on the pulse cycle; key held through and after reset
        pif.rawL = 1'b0;
        for (int i = 0; i < 24; i++) begin
            reset = (i == 5 || i == 6) ? 1'b1 : 1'b0;
            tick();
            check($sformatf("rst_pulse.%0d L", i), pif.L, 1'b0);
        end
        reset    = 1'b0;
        pif.rawL = 1'b1;
        repeat (10) tick();

        // N=1, active-high build: pulse two edges after the first active sample
        rst1 = 1'b1;
        pif1.rawL = 1'b0;
        pif1.rawR = 1'b0;
        repeat (2) tick();
        check("n1 reset L", pif1.L, 1'b0);
        rst1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("n1 idle.%0d L", i), pif1.L, 1'b0);
        end
        for (int r = 0; r < 2; r++) begin
            pif1.rawL = 1'b1;
            for (int i = 0; i < 5; i++) begin
                tick();
                check($sformatf("n1 press%0d.%0d L", r, i), pif1.L, logic'(i == 2));
                check($sformatf("n1 press%0d.%0d R", r, i), pif1.R, 1'b0);
            end
            pif1.rawL = 1'b0;
            for (int i = 0; i < 5; i++) begin
                tick();
                check($sformatf("n1 rel%0d.%0d L", r, i), pif1.L, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
